// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
package dmem_access_unit_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_MEM_AW = 10;
    localparam int unsigned DMEM_DATA_W = 32;

    // One-hot access states
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RD   = 4'b0010,
        ST_WR   = 4'b0100,
        ST_RESP = 4'b1000
    } state_e;

    // Store format codes
    localparam logic [1:0] FMT_SW  = 2'b00;
    localparam logic [1:0] FMT_SH  = 2'b01;
    localparam logic [1:0] FMT_SB  = 2'b10;
    // Load format codes share the same encoding
    localparam logic [1:0] FMT_LW  = 2'b00;
    localparam logic [1:0] FMT_LH  = 2'b01;
    localparam logic [1:0] FMT_LB  = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    // Request fields captured at accept
    typedef struct packed {
        logic                   we;
        logic [1:0]             addr_lo;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [1:0]             store_fmt;
        logic [1:0]             load_fmt;
        logic                   load_sext;
    } req_t;

    // Illegal format or address not aligned to the access size
    function automatic logic fmt_err(input logic [1:0] fmt, input logic [1:0] addr_lo);
        fmt_err = (fmt == FMT_ILL)
               || ((fmt == FMT_SH) && addr_lo[0])
               || ((fmt == FMT_SW) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_mux.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module dmem_lane_mux
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]             addr_lo,
    input  logic [1:0]             load_fmt,
    input  logic                   load_sext,
    input  logic [1:0]             store_fmt,
    input  logic [DMEM_DATA_W-1:0] mem_rdata,
    input  logic [DMEM_DATA_W-1:0] store_data,
    output logic [DMEM_DATA_W-1:0] load_data_c,
    output logic [DMEM_DATA_W-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then extend it for loads or splice new data for stores
    always_comb begin
        byte_sel     = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel     = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data_c  = mem_rdata;
        merge_data_c = store_data;

        case (load_fmt)
            FMT_LH:  load_data_c = {{16{load_sext & half_sel[15]}}, half_sel};
            FMT_LB:  load_data_c = {{24{load_sext & byte_sel[7]}}, byte_sel};
            default: load_data_c = mem_rdata;
        endcase

        case (store_fmt)
            FMT_SH: begin
                merge_data_c = mem_rdata;
                merge_data_c[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            end
            FMT_SB: begin
                merge_data_c = mem_rdata;
                merge_data_c[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            default: merge_data_c = store_data;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory responder: load/store requests against a word memory with ack handshake.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned MEM_AW = DMEM_MEM_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    input  logic [1:0]             store_format_signal,
    input  logic [1:0]             dmem2ref_signal,
    input  logic                   load_sext,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DMEM_DATA_W-1:0] resp_rdata,
    output logic                   resp_err,
    output logic [MEM_AW-1:0]      mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [DMEM_DATA_W-1:0] mem_wdata,
    input  logic [DMEM_DATA_W-1:0] mem_rdata,
    input  logic                   mem_ack
);

    state_e                 state_q, state_d;
    req_t                   req_q, req_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [DMEM_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic                   resp_err_q, resp_err_d;
    logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic [DMEM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]             acc_fmt;
    logic [DMEM_DATA_W-1:0] load_data_c;
    logic [DMEM_DATA_W-1:0] merge_data_c;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_AW+2];

    // Lane extraction and merge on the latched request
    dmem_lane_mux u_lane_mux (
        .addr_lo      (req_q.addr_lo),
        .load_fmt     (req_q.load_fmt),
        .load_sext    (req_q.load_sext),
        .store_fmt    (req_q.store_fmt),
        .mem_rdata    (mem_rdata),
        .store_data   (req_q.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Next state, capture and registered-output decode
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        acc_fmt      = req_we ? store_format_signal : dmem2ref_signal;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.we        = req_we;
                    req_d.addr_lo   = req_addr[1:0];
                    req_d.wdata     = req_wdata;
                    req_d.store_fmt = store_format_signal;
                    req_d.load_fmt  = dmem2ref_signal;
                    req_d.load_sext = load_sext;
                    mem_addr_d      = req_addr[MEM_AW+1:2];
                    resp_rdata_d    = '0;
                    resp_err_d      = 1'b0;
                    if (fmt_err(acc_fmt, req_addr[1:0])) begin
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end else if (req_we && (store_format_signal == FMT_SW)) begin
                        mem_wdata_d = req_wdata;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    if (req_q.we) begin
                        mem_wdata_d = merge_data_c;
                        state_d     = ST_WR;
                    end else begin
                        resp_rdata_d = load_data_c;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        mem_rd_d     = (state_d == ST_RD);
        mem_wr_d     = (state_d == ST_WR);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
